fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'h0000_3000, the PC driven after reset.
REQ-002 The block SHALL expose parameter EXC_PC, default 32'h0000_4180, the exception entry PC.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on rising clk).
REQ-005 pc  input  32  current PC from the fetch unit.
REQ-006 stall  input  1  hazard stall request; PC hold.
REQ-007 br_valid  input  1  branch/jump redirect request.
REQ-008 br_target  input  32  redirect target, qualified by br_valid.
REQ-009 exc_req  input  1  exception request.
REQ-010 halt_req  input  1  stop fetching until reset.
REQ-011 npc  output  32  next PC to the fetch unit.
REQ-012 pc_we  output  1  fetch-unit PC write enable.
REQ-013 flush_fd  output  1  insert a bubble into the F/D pipeline register.
REQ-014 state  output  2  FSM state; IDLE=0, RUN=1, STALL=2, HALT=3.

Function
REQ-015 npc, pc_we and flush_fd SHALL be combinational functions of state, inputs and the pending-redirect register; state and pending SHALL be registered.
REQ-016 Sequential PC SHALL be pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-017 IDLE: pc_we=0, npc=RESET_PC, flush_fd=1; next state HALT if halt_req=1, else RUN.
REQ-018 Priority in RUN/STALL SHALL be halt_req > exc_req > misaligned branch > stall > pending > br_valid > sequential.
REQ-019 halt_req=1 in RUN/STALL: pc_we=0, npc=pc, flush_fd=1, pending cleared, next state HALT.
REQ-020 exc_req=1 (also during stall): pc_we=1, npc=EXC_PC, flush_fd=1, pending cleared, next state RUN.
REQ-021 br_valid=1 with br_target[1:0]!=0: handled exactly as exc_req (REQ-020).
REQ-022 stall=1: pc_we=0, npc=pc, flush_fd=0, next state STALL; an aligned br_valid SHALL be latched into pending, overwriting an older pending target.
REQ-023 stall=0 with pending valid: pc_we=1, npc=pending target, flush_fd=0, pending cleared, next state RUN; a simultaneous br_valid SHALL be ignored.
REQ-024 stall=0, no pending, aligned br_valid: pc_we=1, npc=br_target, flush_fd=0 (delay slot preserved).
REQ-025 Otherwise: pc_we=1, npc=pc+4, flush_fd=0, next state RUN.
REQ-026 HALT: pc_we=0, npc=pc, flush_fd=1; all inputs ignored; exit only via reset.

Reset
REQ-027 While reset=0 at a rising edge: state<=IDLE, pending cleared.
REQ-028 While reset=0: outputs SHALL read pc_we=0, npc=RESET_PC, flush_fd=1, regardless of other inputs.
REQ-029 Reset mid-stall or mid-pending SHALL discard the pending redirect; first fetch after reset SHALL be RESET_PC.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: outputs stall_cycles (32) and redirect_cnt (32) exist.
REQ-031 stall_cycles SHALL count cycles in RUN/STALL with stall=1; redirect_cnt SHALL count cycles with pc_we=1 and npc!=pc+4.
REQ-032 Both counters SHALL saturate at 32'hFFFF_FFFF and clear on reset.
REQ-033 Macro undefined: counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 reset=0 two cycles, then 1 -> cycle 0: pc_we=0, npc=32'h3000, flush_fd=1, state=0; cycle 1: state=1, pc=32'h3000, npc=32'h3004, pc_we=1.
REQ-035 stall=1 three cycles, br_valid=1, br_target=32'h3100 in stall cycle 2 -> pc_we=0 throughout; first cycle after stall=0: pc_we=1, npc=32'h3100; following cycle: sequential.
REQ-036 stall=1, exc_req=1 and br_valid=1 in the same cycle -> pc_we=1, npc=32'h4180, flush_fd=1; no later redirect to br_target.
REQ-037 br_valid=1, br_target=32'h3102 -> npc=32'h4180, flush_fd=1; pc=32'hFFFF_FFFC, no events -> npc=0.
REQ-038 halt_req=1 -> state=3, pc_we=0 for 10 cycles despite exc_req/br_valid; reset=0 then 1 -> IDLE then fetch from 32'h3000.
REQ-039 FETCH_PERF_CNT_EN: 5 stall cycles plus 2 redirects -> stall_cycles=5, redirect_cnt=2; with the macro undefined, the build has no counter ports.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch redirect controller: picks the next PC and F/D flush from stall, branch, exception, halt.
// Optional performance counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        halt_req,
    output logic [31:0] npc,
    output logic        pc_we,
    output logic        flush_fd,
    output logic [1:0]  state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] redirect_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StStall = 2'd2,
        StHalt  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] seq_pc;
    logic        br_misaligned;

    assign seq_pc        = pc + 32'd4;
    assign br_misaligned = br_valid && (br_target[1:0] != 2'b00);
    assign state         = state_q;

    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        npc           = pc;
        pc_we         = 1'b0;
        flush_fd      = 1'b0;

        unique case (state_q)
            StIdle: begin
                npc      = RESET_PC;
                flush_fd = 1'b1;
                state_d  = halt_req ? StHalt : StRun;
            end
            StRun, StStall: begin
                if (halt_req) begin
                    flush_fd     = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = StHalt;
                end else if (exc_req || br_misaligned) begin
                    pc_we        = 1'b1;
                    npc          = EXC_PC;
                    flush_fd     = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = StRun;
                end else if (stall) begin
                    state_d = StStall;
                    // Newest aligned redirect wins while the PC is held.
                    if (br_valid) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = br_target;
                    end
                end else if (pend_valid_q) begin
                    pc_we        = 1'b1;
                    npc          = pend_target_q;
                    pend_valid_d = 1'b0;
                    state_d      = StRun;
                end else if (br_valid) begin
                    pc_we   = 1'b1;
                    npc     = br_target;
                    state_d = StRun;
                end else begin
                    pc_we   = 1'b1;
                    npc     = seq_pc;
                    state_d = StRun;
                end
            end
            StHalt: begin
                flush_fd = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!reset) begin
            npc      = RESET_PC;
            pc_we    = 1'b0;
            flush_fd = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles_q, redirect_cnt_q;
    logic        stall_evt, redirect_evt;

    assign stall_evt    = ((state_q == StRun) || (state_q == StStall)) && stall;
    assign redirect_evt = pc_we && (npc != seq_pc);

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_q <= 32'h0;
            redirect_cnt_q <= 32'h0;
        end else begin
            if (stall_evt && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (redirect_evt && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign redirect_cnt = redirect_cnt_q;
`else
    // Counters are not built; no extra ports or state.
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl, with hand sequences for halt and reset corners.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_req;
    logic        halt_req;
    logic [31:0] npc;
    logic        pc_we;
    logic        flush_fd;
    logic [1:0]  state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] redirect_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fetch_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_target (br_target),
        .exc_req   (exc_req),
        .halt_req  (halt_req),
        .npc       (npc),
        .pc_we     (pc_we),
        .flush_fd  (flush_fd),
        .state     (state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .redirect_cnt (redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        bv;
        logic [31:0] bt;
        logic        exc;
        logic        hlt;
        logic [31:0] pc;
        logic [31:0] e_npc;
        logic        e_we;
        logic        e_fl;
        logic [1:0]  e_st;
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t mk(logic rst, logic stl, logic bv, logic [31:0] bt, logic exc,
                                logic hlt, logic [31:0] p, logic [31:0] e_npc, logic e_we,
                                logic e_fl, logic [1:0] e_st);
        vec_t v;
        v.rst = rst; v.stl = stl; v.bv = bv; v.bt = bt; v.exc = exc; v.hlt = hlt; v.pc = p;
        v.e_npc = e_npc; v.e_we = e_we; v.e_fl = e_fl; v.e_st = e_st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e_npc, input logic e_we,
                              input logic e_fl, input logic [1:0] e_st);
        check({tag, ".npc"}, npc, e_npc);
        check({tag, ".pc_we"}, {31'h0, pc_we}, {31'h0, e_we});
        check({tag, ".flush_fd"}, {31'h0, flush_fd}, {31'h0, e_fl});
        check({tag, ".state"}, {30'h0, state}, {30'h0, e_st});
    endtask

    task automatic drive(input logic rst, input logic stl, input logic bv, input logic [31:0] bt,
                         input logic exc, input logic hlt, input logic [31:0] p);
        reset = rst; stall = stl; br_valid = bv; br_target = bt;
        exc_req = exc; halt_req = hlt; pc = p;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        //          rst stl bv  bt            exc hlt pc             npc           we  fl  st
        vecs[0]  = mk(0, 1, 1, 32'h0000_3200, 1, 1, 32'h0000_1234, 32'h0000_3000, 0, 1, 2'd0);
        vecs[1]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0000_3000, 32'h0000_3000, 0, 1, 2'd0);
        vecs[2]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0000_3000, 32'h0000_3000, 0, 1, 2'd0);
        vecs[3]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0000_3000, 32'h0000_3004, 1, 0, 2'd1);
        vecs[4]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0000_3004, 32'h0000_3008, 1, 0, 2'd1);
        vecs[5]  = mk(1, 1, 0, 32'h0,         0, 0, 32'h0000_3008, 32'h0000_3008, 0, 0, 2'd1);
        vecs[6]  = mk(1, 1, 1, 32'h0000_3100, 0, 0, 32'h0000_3008, 32'h0000_3008, 0, 0, 2'd2);
        vecs[7]  = mk(1, 1, 0, 32'h0,         0, 0, 32'h0000_3008, 32'h0000_3008, 0, 0, 2'd2);
        vecs[8]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0000_3008, 32'h0000_3100, 1, 0, 2'd2);
        vecs[9]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0000_3100, 32'h0000_3104, 1, 0, 2'd1);
        vecs[10] = mk(1, 1, 1, 32'h0000_3200, 0, 0, 32'h0000_3104, 32'h0000_3104, 0, 0, 2'd1);
        vecs[11] = mk(1, 1, 1, 32'h0000_3300, 0, 0, 32'h0000_3104, 32'h0000_3104, 0, 0, 2'd2);
        vecs[12] = mk(1, 0, 1, 32'h0000_3400, 0, 0, 32'h0000_3104, 32'h0000_3300, 1, 0, 2'd2);
        vecs[13] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0000_3300, 32'h0000_3304, 1, 0, 2'd1);
        vecs[14] = mk(1, 1, 1, 32'h0000_3500, 1, 0, 32'h0000_3304, 32'h0000_4180, 1, 1, 2'd1);
        vecs[15] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0000_4180, 32'h0000_4184, 1, 0, 2'd1);
        vecs[16] = mk(1, 1, 1, 32'h0000_3600, 0, 0, 32'h0000_4184, 32'h0000_4184, 0, 0, 2'd1);
        vecs[17] = mk(1, 1, 0, 32'h0,         1, 0, 32'h0000_4184, 32'h0000_4180, 1, 1, 2'd2);
        vecs[18] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0000_4180, 32'h0000_4184, 1, 0, 2'd1);
        vecs[19] = mk(1, 0, 1, 32'h0000_3102, 0, 0, 32'h0000_4184, 32'h0000_4180, 1, 1, 2'd1);
        vecs[20] = mk(1, 0, 0, 32'h0,         0, 0, 32'hFFFF_FFFC, 32'h0000_0000, 1, 0, 2'd1);
        vecs[21] = mk(1, 0, 1, 32'h0000_3700, 0, 0, 32'h0000_0000, 32'h0000_3700, 1, 0, 2'd1);
        vecs[22] = mk(1, 1, 1, 32'h0000_3103, 0, 0, 32'h0000_3700, 32'h0000_4180, 1, 1, 2'd1);
        vecs[23] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0000_4180, 32'h0000_4184, 1, 0, 2'd1);
        vecs[24] = mk(1, 1, 1, 32'h0000_3800, 0, 0, 32'h0000_4184, 32'h0000_4184, 0, 0, 2'd1);
        vecs[25] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0000_4184, 32'h0000_3000, 0, 1, 2'd2);
        vecs[26] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0000_3000, 32'h0000_3000, 0, 1, 2'd0);
        vecs[27] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0000_3000, 32'h0000_3004, 1, 0, 2'd1);
        vecs[28] = mk(1, 0, 1, 32'h0000_3900, 1, 1, 32'h0000_3004, 32'h0000_3004, 0, 1, 2'd1);

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].stl, vecs[i].bv, vecs[i].bt, vecs[i].exc, vecs[i].hlt,
                  vecs[i].pc);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_npc, vecs[i].e_we, vecs[i].e_fl,
                       vecs[i].e_st);
        end

        // Halted: nothing but reset gets out.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, 32'h0000_3A00 + 32'(i),
                  1'($urandom_range(0, 1)), 1'b0, 32'h0000_3004);
            #1;
            check_outs($sformatf("halt%0d", i), 32'h0000_3004, 1'b0, 1'b1, 2'd3);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_3004);
        #1;
        check_outs("halt_rst", 32'h0000_3000, 1'b0, 1'b1, 2'd3);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_3000);
        #1;
        check_outs("halt_idle", 32'h0000_3000, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        #1;
        check_outs("halt_fetch", 32'h0000_3004, 1'b1, 1'b0, 2'd1);

        // Halt requested straight out of IDLE.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_3000);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3000);
        #1;
        check_outs("idle_halt", 32'h0000_3000, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_3000);
        #1;
        check_outs("idle_halted", 32'h0000_3000, 1'b0, 1'b1, 2'd3);

`ifdef FETCH_PERF_CNT_EN
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_3000);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_3000);
        #1;
        check("cnt_stall_rst", stall_cycles, 32'h0);
        check("cnt_redir_rst", redirect_cnt, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_3000);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_3000);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_3200, 1'b0, 1'b0, 32'h0000_3004);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_3200);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_4180);
        @(negedge clk);
        #1;
        check("cnt_stall", stall_cycles, 32'd5);
        check("cnt_redir", redirect_cnt, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
